fe_req_mux: RTL and testbench
=============================

Name: fe_req_mux

Overview:
Parametrised front-end request collector for the PDP-6 SoC fabric.
- Gathers NCH asynchronous device request lines (paper-tape reader, punch, 340 display, future devices) into the 32-bit request word polled by the HPS front-end.
- Generalises the fixed 3-line, level-only request wiring: synchronises inputs, supports edge-latched pending requests with per-channel acknowledge, masking, priority selection, overrun detection and stretched panel LED drive.

Parameters:
NCH, 8, number of request channels, legal range 1..32.
SYNC_STAGES, 2, synchroniser flops per input, minimum 2.
EDGE_MODE, 1, 1 = rising edge sets a sticky pending bit cleared by ack; 0 = pending follows the synchronised level.
PRESC, 1000, clk cycles per LED stretch tick (1000 at 50 MHz = 50 kHz tick).
STRETCH, 15, LED hold time in ticks after pending clears, range 1..15 (4-bit counter per channel).

Ports:
clk  in  1  system clock (50 MHz).
reset  in  1  asynchronous, active-high reset.
rq_in  in  NCH  raw device request lines, asynchronous to clk.
mask  in  NCH  1 = channel enabled; synchronous to clk.
pend_ack  in  1  single-cycle pulse that acknowledges the channel shown on pend_chan.
ovr_clr  in  1  single-cycle pulse that clears all overrun bits.
req_word  out  32  {zeros, pending & mask}, bit i = channel i.
pend_valid  out  1  at least one masked pending channel exists.
pend_chan  out  5  index of the selected pending channel.
overrun  out  NCH  sticky per-channel overrun flags.
led  out  NCH  stretched activity indication for panel_ext.

Behaviour:
- Reset: all synchroniser, edge and pending flops 0; overrun 0; LED counters 0; prescaler 0; req_word 0; pend_valid 0; pend_chan 0; led 0. Reset is honoured mid-operation with no residue; the round-robin pointer resets to 0.
- Synchroniser: an SYNC_STAGES-deep flop chain per channel produces s[i]. prev[i] is a registered copy of s[i].
- EDGE_MODE=1:
  - rise[i] = s[i] & ~prev[i].
  - pending[i] sets on rise[i] regardless of mask. A masked-off request is therefore remembered and appears when unmasked.
  - pending[i] clears at the edge where pend_ack=1, pend_valid=1 and pend_chan=i.
  - If rise and ack hit the same channel in the same cycle, set wins and pending stays 1.
  - If rise[i] occurs while pending[i]=1 and no ack clears it that cycle, overrun[i] sets.
- EDGE_MODE=0: pending = s, ack is ignored and overrun stays 0.
- Latency: if rq_in[i] rises before edge 1, pending[i] is 1 after edge SYNC_STAGES+1 (edge 3 with defaults). req_word, pend_valid and pend_chan follow combinationally from the pending and mask registers; there is no extra pipeline stage.
- Selection: pend_chan is the lowest index i with pending[i] & mask[i].
  - If no channel qualifies, pend_valid=0 and pend_chan=0.
  - pend_ack while pend_valid=0 is ignored.
  - After an ack, the next cycle shows the next candidate or pend_valid=0.
- Overrun: ovr_clr clears all overrun bits. If ovr_clr and a new overrun hit the same cycle, the new overrun wins and the bit stays set.
- Width rules:
  - req_word[31:NCH] is always 0.
  - For NCH<32, pend_chan never exceeds NCH-1.
  - pend_chan is zero-extended to 5 bits.
- LED stretch:
  - A prescaler counts 0..PRESC-1 and emits tick when it wraps.
  - cnt[i] loads STRETCH every cycle that pending[i]=1. Otherwise it decrements by 1 on tick and saturates at 0.
  - led[i] = pending[i] | (cnt[i]!=0).
  - A mask bit does not affect led.

Optional Feature:
FE_REQ_MUX_ROTATE_EN
- Defined: round-robin selection.
  - A pointer rr (5 bits, reset 0) starts the search, wrapping modulo NCH.
  - On an accepted ack of channel c, rr becomes (c+1) mod NCH.
  - pend_chan is the first masked pending channel at or after rr.
- Undefined: fixed lowest-index priority as above; no rr register is synthesised.

Test Plan:
1. Reset with NCH=8, rq_in=8'h00 -> all outputs 0. Then pulse rq_in[2] high for 1 cycle -> pend_valid=1, pend_chan=2, req_word=32'h4 after 3 edges.
2. Pending on channels 1 and 5, mask=8'hFF -> pend_chan=1; ack -> pend_chan=5 next cycle; ack -> pend_valid=0, req_word=0.
3. mask=8'hDF, pending on channel 5 -> pend_valid=0. Set mask=8'hFF -> pend_chan=5 the same cycle.
4. Channel 3 pending; second rising edge before ack -> overrun=8'h08. Rise coincident with ack -> pending stays 1. ovr_clr -> overrun=0.
5. PRESC=4, STRETCH=3, pending[0] cleared by ack -> led[0] remains 1 for 3 ticks (12±4 clk), then 0. Assert reset mid-stretch -> led=0 immediately.
6. FE_REQ_MUX_ROTATE_EN defined, channels 0, 2 and 6 held pending by re-raising each after ack -> ack sequence yields pend_chan 0, 2, 6, 0. With the macro undefined -> 0, 0, 0.

Source files
------------

// File: rtl/fe_req_mux.sv
// ============================================================================
// fe_req_mux: synchronised, masked, prioritised device request collector.
// Optional FE_REQ_MUX_ROTATE_EN selects round-robin instead of fixed priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module fe_req_mux #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int PRESC       = 1000,
  parameter int STRETCH     = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  rq_in,
  input  logic [NCH-1:0]  mask,
  input  logic            pend_ack,
  input  logic            ovr_clr,
  output logic [31:0]     req_word,
  output logic            pend_valid,
  output logic [4:0]      pend_chan,
  output logic [NCH-1:0]  overrun,
  output logic [NCH-1:0]  led
);

  localparam int          PW  = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [3:0]  STR = 4'(STRETCH);

  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] s;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] qual;
  logic [NCH-1:0] ack_vec;
  logic           accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= rq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end
  assign s = sync_q[SYNC_STAGES-1];

  assign qual   = pending & mask;
  assign accept = pend_ack & pend_valid & (EDGE_MODE != 0);

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NCH; i++)
      ack_vec[i] = accept & (pend_chan == 5'(i));
  end

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [NCH-1:0] prev;
      logic [NCH-1:0] pend_q;
      logic [NCH-1:0] ovr_q;
      logic [NCH-1:0] rise;

      assign rise = s & ~prev;

      // A rise on the acked channel re-arms it; it is not an overrun.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          prev   <= '0;
          pend_q <= '0;
          ovr_q  <= '0;
        end else begin
          prev   <= s;
          pend_q <= (pend_q & ~ack_vec) | rise;
          ovr_q  <= (ovr_clr ? '0 : ovr_q) | (rise & pend_q & ~ack_vec);
        end
      end
      assign pending = pend_q;
      assign overrun = ovr_q;
    end else begin : g_level
      wire unused_level = &{1'b0, ovr_clr, ack_vec};
      assign pending = s;
      assign overrun = '0;
    end
  endgenerate

  always_comb begin
    req_word          = '0;
    req_word[NCH-1:0] = qual;
  end

`ifdef FE_REQ_MUX_ROTATE_EN
  logic [4:0] rr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr <= '0;
    else if (accept)
      rr <= (pend_chan == 5'(NCH-1)) ? 5'd0 : pend_chan + 5'd1;
  end

  // Lowest qualifier at or above rr wins; otherwise wrap to the lowest overall.
  always_comb begin
    logic hi_found;
    logic [4:0] hi_chan;
    logic [4:0] lo_chan;
    hi_found   = 1'b0;
    hi_chan    = '0;
    lo_chan    = '0;
    pend_valid = 1'b0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (qual[i]) begin
        lo_chan    = 5'(i);
        pend_valid = 1'b1;
        if (5'(i) >= rr) begin
          hi_found = 1'b1;
          hi_chan  = 5'(i);
        end
      end
    end
    pend_chan = hi_found ? hi_chan : lo_chan;
  end
`else
  always_comb begin
    pend_valid = 1'b0;
    pend_chan  = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (qual[i]) begin
        pend_valid = 1'b1;
        pend_chan  = 5'(i);
      end
    end
  end
`endif

  logic [PW-1:0] prsc;
  logic          tick;
  logic [3:0]    cnt [NCH];

  assign tick = (prsc == PW'(PRESC-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prsc <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      prsc <= tick ? '0 : prsc + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (pending[i])
          cnt[i] <= STR;
        else if (tick && cnt[i] != 4'd0)
          cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < NCH; i++)
      led[i] = pending[i] | (cnt[i] != 4'd0);
  end

endmodule

`default_nettype wire

// File: tb/tb_fe_req_mux.sv
// ============================================================================
// tb_fe_req_mux: directed self-checking bench for fe_req_mux (NCH=8).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fe_req_mux;

  localparam int NCH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  rq_in;
  logic [NCH-1:0]  mask;
  logic            pend_ack;
  logic            ovr_clr;
  logic [31:0]     req_word;
  logic            pend_valid;
  logic [4:0]      pend_chan;
  logic [NCH-1:0]  overrun;
  logic [NCH-1:0]  led;

  int n_checks = 0;
  int n_pass   = 0;

  fe_req_mux #(
    .NCH(NCH), .SYNC_STAGES(2), .EDGE_MODE(1), .PRESC(4), .STRETCH(3)
  ) dut (
    .clk(clk), .reset(reset), .rq_in(rq_in), .mask(mask),
    .pend_ack(pend_ack), .ovr_clr(ovr_clr), .req_word(req_word),
    .pend_valid(pend_valid), .pend_chan(pend_chan), .overrun(overrun), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; rq_in = '0; mask = '1; pend_ack = 1'b0; ovr_clr = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // One-cycle request pulse; the bit is pending after two further edges.
  task automatic pulse(input logic [NCH-1:0] v);
    rq_in = v;
    tick(1);
    rq_in = '0;
  endtask

  task automatic ack();
    pend_ack = 1'b1;
    tick(1);
    pend_ack = 1'b0;
  endtask

  initial begin
    int cycles;
    logic [4:0] seq [4];
    logic [4:0] exp_seq [4];

    // 1: reset values and first-request latency
    do_reset();
    check("rst_req_word", req_word, 32'h0);
    check("rst_pend_valid", {31'd0, pend_valid}, 32'd0);
    check("rst_pend_chan", {27'd0, pend_chan}, 32'd0);
    check("rst_overrun", {24'd0, overrun}, 32'd0);
    check("rst_led", {24'd0, led}, 32'd0);
    pulse(8'h04);
    tick(1);
    check("lat_not_yet", req_word, 32'h0);
    tick(1);
    check("lat_req_word", req_word, 32'h4);
    check("lat_pend_valid", {31'd0, pend_valid}, 32'd1);
    check("lat_pend_chan", {27'd0, pend_chan}, 32'd2);

    // 2: priority and ack sequencing
    do_reset();
    pulse(8'h22);
    tick(2);
    check("prio_word", req_word, 32'h22);
    check("prio_chan1", {27'd0, pend_chan}, 32'd1);
    ack();
    check("prio_chan5", {27'd0, pend_chan}, 32'd5);
    check("prio_word5", req_word, 32'h20);
    ack();
    check("prio_empty_valid", {31'd0, pend_valid}, 32'd0);
    check("prio_empty_word", req_word, 32'h0);

    // 3: masked pending is remembered, ack with no valid ignored
    do_reset();
    mask = 8'hDF;
    pulse(8'h20);
    tick(2);
    check("mask_valid0", {31'd0, pend_valid}, 32'd0);
    check("mask_word0", req_word, 32'h0);
    ack();
    mask = 8'hFF;
    #1;
    check("unmask_valid", {31'd0, pend_valid}, 32'd1);
    check("unmask_chan", {27'd0, pend_chan}, 32'd5);

    // 4: overrun, set-wins-over-ack, clear-vs-new-overrun
    do_reset();
    pulse(8'h08);
    tick(2);
    pulse(8'h08);
    tick(2);
    check("ovr_set", {24'd0, overrun}, 32'h08);
    check("ovr_still_pend", req_word, 32'h08);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    check("ovr_cleared", {24'd0, overrun}, 32'h0);
    pulse(8'h08);
    tick(1);
    ack();
    check("rise_ack_pend", req_word, 32'h08);
    check("rise_ack_no_ovr", {24'd0, overrun}, 32'h0);
    pulse(8'h08);
    tick(1);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    check("clr_vs_new_ovr", {24'd0, overrun}, 32'h08);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    check("ovr_cleared2", {24'd0, overrun}, 32'h0);

    // 5: LED stretch of 3 ticks of 4 clocks, then reset mid-stretch
    do_reset();
    pulse(8'h01);
    tick(2);
    ack();
    check("led_after_ack", {31'd0, led[0]}, 32'd1);
    check("led_pend_gone", req_word, 32'h0);
    cycles = 0;
    while (led[0] && cycles < 40) begin
      tick(1);
      cycles++;
    end
    check("led_off", {31'd0, led[0]}, 32'd0);
    check("led_stretch_ge8", {31'd0, (cycles >= 8)}, 32'd1);
    check("led_stretch_le16", {31'd0, (cycles <= 16)}, 32'd1);
    pulse(8'h01);
    tick(2);
    ack();
    tick(3);
    check("led_mid_stretch", {31'd0, led[0]}, 32'd1);
    reset = 1'b1;
    #1;
    check("led_async_reset", {24'd0, led}, 32'd0);
    tick(1);
    reset = 1'b0;

    // 6: re-raised channels 0, 2, 6 through four acks
    do_reset();
    pulse(8'h45);
    tick(2);
`ifdef FE_REQ_MUX_ROTATE_EN
    exp_seq[0] = 5'd0; exp_seq[1] = 5'd2; exp_seq[2] = 5'd6; exp_seq[3] = 5'd0;
`else
    exp_seq[0] = 5'd0; exp_seq[1] = 5'd0; exp_seq[2] = 5'd0; exp_seq[3] = 5'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      seq[k] = pend_chan;
      check($sformatf("rr_seq%0d", k), {27'd0, seq[k]}, {27'd0, exp_seq[k]});
      ack();
      pulse(NCH'(1) << seq[k]);
      tick(2);
    end
    check("rr_all_pend", req_word, 32'h45);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
